// File: rtl/board_io_frontend.sv
// Board I/O conditioning between the FPGA pins and the CPU top: switch and button
// synchronisers, per-button debounce with rising-edge pulses, the program-mode latch,
// the CPU reset request and a registered LED drive with a heartbeat in program mode.
// Optional feature macro: BOARD_IO_LONGPRESS_EN. When defined, the CPU reset request
// only asserts after the reset button has been held for LONG_CYCLES cycles.
module board_io_frontend #(
    parameter int unsigned SW_W         = 24,
    parameter int unsigned LED_W        = 24,
    parameter int unsigned BTN_N        = 5,
    parameter int unsigned DB_CYCLES    = 20000,
    parameter int unsigned PG_IDX       = 4,
    parameter int unsigned RST_IDX      = 3,
    parameter int unsigned BLINK_CYCLES = 50000000,
    parameter int unsigned LONG_CYCLES  = 100000000
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst,
    input  logic [SW_W-1:0]  sw_pin,
    input  logic [BTN_N-1:0] btn_pin,
    input  logic [LED_W-1:0] led_cpu,
    output logic [SW_W-1:0]  sw_out,
    output logic [LED_W-1:0] led_pin,
    output logic [BTN_N-1:0] btn_level,
    output logic [BTN_N-1:0] btn_rise,
    output logic             prog_mode,
    output logic             cpu_rst_req
);

    localparam int unsigned DbW    = $clog2(DB_CYCLES);
    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES);
    localparam logic [DbW-1:0]    DbMax    = DbW'(DB_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_CYCLES - 1);

    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
    logic [BTN_N-1:0]  btn_meta_q, btn_sync_q;
    logic [DbW-1:0]    db_cnt_q [BTN_N];
    logic [DbW-1:0]    db_cnt_d [BTN_N];
    logic [BTN_N-1:0]  btn_level_q, btn_level_d;
    logic [BTN_N-1:0]  btn_prev_q;
    logic              prog_mode_q, prog_mode_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;
    logic [LED_W-1:0]  led_q, led_d, led_prog;

    assign btn_rise    = btn_level_q & ~btn_prev_q;
    assign sw_out      = sw_sync_q;
    assign btn_level   = btn_level_q;
    assign prog_mode   = prog_mode_q;
    assign led_pin     = led_q;
    assign prog_mode_d = prog_mode_q ^ btn_rise[PG_IDX];

    // Debounce: a level change is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
        btn_level_d = btn_level_q;
        for (int i = 0; i < int'(BTN_N); i++) begin
            db_cnt_d[i] = '0;
            if (btn_sync_q[i] != btn_level_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    btn_level_d[i] = btn_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Heartbeat runs only in program mode, so each entry starts from a cleared phase.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (prog_mode_q) begin
            if (blink_cnt_q == BlinkMax) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    // LED source: CPU value in run mode, heartbeat on the MSB in program mode.
    always_comb begin
        led_prog            = '0;
        led_prog[LED_W-1]   = blink_q;
        led_d               = prog_mode_q ? led_prog : led_cpu;
    end

    // All state registers with synchronous active-low clear.
    always_ff @(posedge fpga_clk) begin
        if (!fpga_rst) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            btn_level_q <= '0;
            btn_prev_q  <= '0;
            prog_mode_q <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            led_q       <= '0;
            for (int i = 0; i < int'(BTN_N); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sw_meta_q   <= sw_pin;
            sw_sync_q   <= sw_meta_q;
            btn_meta_q  <= btn_pin;
            btn_sync_q  <= btn_meta_q;
            btn_level_q <= btn_level_d;
            btn_prev_q  <= btn_level_q;
            prog_mode_q <= prog_mode_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            led_q       <= led_d;
            for (int i = 0; i < int'(BTN_N); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

`ifdef BOARD_IO_LONGPRESS_EN
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES);

    logic [HoldW-1:0] hold_q, hold_d;

    // Saturating hold timer for the reset button.
    always_comb begin
        hold_d = '0;
        if (btn_level_q[RST_IDX]) begin
            hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
        end
    end

    // Hold timer register.
    always_ff @(posedge fpga_clk) begin
        if (!fpga_rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Gate with the live level so the request drops the cycle the button is released.
    assign cpu_rst_req = btn_level_q[RST_IDX] && (hold_q == HoldMax);
`else
    assign cpu_rst_req = btn_level_q[RST_IDX];
`endif

endmodule

// File: tb/tb_board_io_frontend.sv
// Directed bench for board_io_frontend with short debounce, blink and hold times.
module tb_board_io_frontend;

    localparam int unsigned SwW  = 24;
    localparam int unsigned LedW = 24;
    localparam int unsigned BtnN = 5;

`ifdef BOARD_IO_LONGPRESS_EN
    localparam logic [31:0] ReqOnAccept = 32'd0;
    localparam logic [31:0] ReqOnTap    = 32'd0;
`else
    localparam logic [31:0] ReqOnAccept = 32'd1;
    localparam logic [31:0] ReqOnTap    = 32'd1;
`endif

    logic            fpga_clk = 1'b0;
    logic            fpga_rst;
    logic [SwW-1:0]  sw_pin;
    logic [BtnN-1:0] btn_pin;
    logic [LedW-1:0] led_cpu;
    logic [SwW-1:0]  sw_out;
    logic [LedW-1:0] led_pin;
    logic [BtnN-1:0] btn_level;
    logic [BtnN-1:0] btn_rise;
    logic            prog_mode;
    logic            cpu_rst_req;

    int n_pass  = 0;
    int n_total = 0;

    board_io_frontend #(
        .SW_W        (SwW),
        .LED_W       (LedW),
        .BTN_N       (BtnN),
        .DB_CYCLES   (4),
        .PG_IDX      (4),
        .RST_IDX     (3),
        .BLINK_CYCLES(3),
        .LONG_CYCLES (6)
    ) dut (
        .fpga_clk   (fpga_clk),
        .fpga_rst   (fpga_rst),
        .sw_pin     (sw_pin),
        .btn_pin    (btn_pin),
        .led_cpu    (led_cpu),
        .sw_out     (sw_out),
        .led_pin    (led_pin),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .prog_mode  (prog_mode),
        .cpu_rst_req(cpu_rst_req)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge fpga_clk);
            #1;
        end
    endtask

    initial begin
        bit   pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic seen_a;
        logic seen_b;

        // Reset with every pin high.
        fpga_rst = 1'b0;
        sw_pin   = '1;
        btn_pin  = '1;
        led_cpu  = '0;
        step(3);
        check("rst_sw_out", 32'(sw_out), 32'h0);
        check("rst_led_pin", 32'(led_pin), 32'h0);
        check("rst_btn_level", 32'(btn_level), 32'h0);
        check("rst_btn_rise", 32'(btn_rise), 32'h0);
        check("rst_prog_mode", 32'(prog_mode), 32'h0);
        check("rst_cpu_rst_req", 32'(cpu_rst_req), 32'h0);

        fpga_rst = 1'b1;
        step(1);
        check("sw_edge1", 32'(sw_out), 32'h0);
        step(1);
        check("sw_edge2", 32'(sw_out), 32'hFFFFFF);
        step(3);
        check("level_edge5", 32'(btn_level), 32'h0);
        step(1);
        check("level_edge6", 32'(btn_level), 32'h1F);
        check("rise_edge6", 32'(btn_rise), 32'h1F);
        check("req_edge6", 32'(cpu_rst_req), ReqOnAccept);
        check("prog_edge6", 32'(prog_mode), 32'h0);
        step(1);
        check("rise_edge7", 32'(btn_rise), 32'h0);
        check("prog_edge7", 32'(prog_mode), 32'h1);

        // Clean restart with pins low.
        btn_pin  = '0;
        sw_pin   = '0;
        fpga_rst = 1'b0;
        step(2);
        check("rerst_prog", 32'(prog_mode), 32'h0);
        check("rerst_level", 32'(btn_level), 32'h0);
        fpga_rst = 1'b1;

        // Switches pass through with two-edge latency.
        sw_pin = 24'h3C0F5A;
        step(1);
        check("sw_lat1", 32'(sw_out), 32'h0);
        step(1);
        check("sw_lat2", 32'(sw_out), 32'h3C0F5A);

        // Bounce on button 0, then a clean final rise.
        seen_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn_pin[0] = pat[k];
            step(1);
            seen_a = seen_a | btn_level[0];
        end
        btn_pin[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            seen_a = seen_a | btn_level[0];
        end
        check("bounce_no_level", 32'(seen_a), 32'h0);
        step(1);
        check("bounce_level6", 32'(btn_level), 32'h01);
        check("bounce_rise6", 32'(btn_rise), 32'h01);
        step(1);
        check("bounce_rise7", 32'(btn_rise), 32'h0);
        btn_pin[0] = 1'b0;
        seen_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            seen_b = seen_b | btn_rise[0];
        end
        check("release_no_rise", 32'(seen_b), 32'h0);
        check("release_level", 32'(btn_level), 32'h0);

        // Enter program mode and watch the heartbeat.
        led_cpu    = 24'hA5A5A5;
        btn_pin[4] = 1'b1;
        step(6);
        check("pg_rise", 32'(btn_rise), 32'h10);
        step(1);
        check("pg_prog_on", 32'(prog_mode), 32'h1);
        check("pg_led_p0", 32'(led_pin), 32'hA5A5A5);
        btn_pin[4] = 1'b0;
        step(1);
        check("pg_led_p1", 32'(led_pin), 32'h0);
        step(2);
        check("pg_led_p3", 32'(led_pin), 32'h0);
        step(1);
        check("pg_led_p4", 32'(led_pin), 32'h800000);
        step(2);
        check("pg_led_p6", 32'(led_pin), 32'h800000);
        step(1);
        check("pg_led_p7", 32'(led_pin), 32'h0);

        // Leave program mode; LEDs follow the CPU one cycle later.
        btn_pin[4] = 1'b1;
        step(7);
        check("pg_prog_off", 32'(prog_mode), 32'h0);
        step(1);
        check("run_led_a5", 32'(led_pin), 32'hA5A5A5);
        led_cpu = 24'h123456;
        step(1);
        check("run_led_follow", 32'(led_pin), 32'h123456);
        btn_pin[4] = 1'b0;
        step(7);
        check("pg_release_keep", 32'(prog_mode), 32'h0);

        // PG and RST accepted on the same cycle.
        btn_pin = 5'b11000;
        step(6);
        check("sim_rise", 32'(btn_rise), 32'h18);
        check("sim_req_a0", 32'(cpu_rst_req), ReqOnAccept);
        check("sim_prog_a0", 32'(prog_mode), 32'h0);
        step(1);
        check("sim_prog_a1", 32'(prog_mode), 32'h1);
        check("sim_req_a1", 32'(cpu_rst_req), ReqOnAccept);
        step(4);
        check("hold_req_a5", 32'(cpu_rst_req), ReqOnAccept);
        step(1);
        check("hold_req_a6", 32'(cpu_rst_req), 32'h1);
        btn_pin = '0;
        step(5);
        check("hold_req_before_fall", 32'(cpu_rst_req), 32'h1);
        step(1);
        check("hold_req_at_fall", 32'(cpu_rst_req), 32'h0);
        check("hold_level_fall", 32'(btn_level), 32'h0);

        // Short tap on RST: level high for four cycles.
        btn_pin[3] = 1'b1;
        step(4);
        btn_pin[3] = 1'b0;
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            seen_a = seen_a | btn_level[3];
            seen_b = seen_b | cpu_rst_req;
        end
        check("tap_level", 32'(seen_a), 32'h1);
        check("tap_req", 32'(seen_b), ReqOnTap);

        // Reset in the middle of a debounce count with the button held.
        btn_pin[0] = 1'b1;
        step(4);
        fpga_rst = 1'b0;
        step(1);
        check("midrst_prog", 32'(prog_mode), 32'h0);
        check("midrst_level", 32'(btn_level), 32'h0);
        check("midrst_led", 32'(led_pin), 32'h0);
        fpga_rst = 1'b1;
        step(5);
        check("midrst_level5", 32'(btn_level), 32'h0);
        step(1);
        check("midrst_level6", 32'(btn_level), 32'h01);
        check("midrst_rise6", 32'(btn_rise), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
